mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit_pkg.sv | 27 ++
 rtl/muldiv_iter_core.sv | 63 ++++++
 rtl/mul_div_unit.sv | 148 ++++++++++++++
 tb/tb_mul_div_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// ============================================================================
// Module : mul_div_unit_pkg
// Brief  : Shared op encodings, FSM state type and default sizes for the
//          MIPS multiply/divide unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mul_div_unit_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_iter_core.sv
// ============================================================================
// Module : muldiv_iter_core
// Brief  : 2*WIDTH shift register with one shift-add (multiply) or one
//          restoring-subtract (divide) step per enabled cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module muldiv_iter_core
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 div_mode_i,
  input  logic [2*WIDTH-1:0]   acc_init_i,
  input  logic [WIDTH-1:0]     operand_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH:0]     sum, diff;

  // Multiply: upper half accumulates, lower half holds the unconsumed
  // multiplier bits. Divide: upper half is the partial remainder, lower half
  // shifts dividend bits out and quotient bits in.
  always_comb begin
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    diff   = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    acc_d  = acc_q;
    opnd_d = opnd_q;
    if (load_i) begin
      acc_d  = acc_init_i;
      opnd_d = operand_i;
    end else if (step_i) begin
      if (div_mode_i) begin
        if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else              acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
      end else begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
    end
  end

  assign acc_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module : mul_div_unit
// Brief  : Multi-cycle MIPS MULT/MULTU/DIV/DIVU unit with HI/LO registers.
//          Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q, neg_q_q, neg_r_q, divz_q, done_q;
  logic [WIDTH-1:0]   dvd_q, hi_q, lo_q;

  logic               op_div, op_signed, rs_neg, rt_neg, fast_mul;
  logic               core_load, core_step;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [2*WIDTH-1:0] acc_init, acc;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign rs_neg    = op_signed & rs_data[WIDTH-1];
  assign rt_neg    = op_signed & rt_data[WIDTH-1];
  assign rs_mag    = rs_neg ? -rs_data : rs_data;
  assign rt_mag    = rt_neg ? -rt_data : rt_data;

`ifdef MULDIV_FAST_MUL_EN
  assign fast_mul = !op_div;
  assign acc_init = op_div ? {{WIDTH{1'b0}}, rs_mag}
                           : ({{WIDTH{1'b0}}, rs_mag} * {{WIDTH{1'b0}}, rt_mag});
`else
  assign fast_mul = 1'b0;
  assign acc_init = {{WIDTH{1'b0}}, rs_mag};
`endif

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .reset      (reset),
    .load_i     (core_load),
    .step_i     (core_step),
    .div_mode_i (is_div_q),
    .acc_init_i (acc_init),
    .operand_i  (rt_mag),
    .acc_o      (acc)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = fast_mul ? S_FINISH : S_RUN;
      S_RUN:    if (cnt_q == '0) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = done_q;
    hi        = hi_q;
    lo        = lo_q;
    core_load = (state_q == S_IDLE) && start;
    core_step = (state_q == S_RUN);
  end

  // Remainder follows the dividend's sign; quotient/product follow the XOR.
  assign prod_s = neg_q_q ? -acc : acc;
  assign quo_s  = neg_q_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_s  = neg_r_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      divz_q   <= 1'b0;
      dvd_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q    <= CNT_W'(WIDTH - 1);
            is_div_q <= op_div;
            neg_q_q  <= rs_neg ^ rt_neg;
            neg_r_q  <= rs_neg;
            divz_q   <= op_div && (rt_data == '0);
            dvd_q    <= rs_data;
          end else begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        S_RUN: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        S_FINISH: begin
          done_q <= 1'b1;
          if (!is_div_q) begin
            hi_q <= prod_s[2*WIDTH-1:WIDTH];
            lo_q <= prod_s[WIDTH-1:0];
          end else if (divz_q) begin
            hi_q <= dvd_q;
            lo_q <= '1;
          end else begin
            hi_q <= rem_s;
            lo_q <= quo_s;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module : tb_mul_div_unit
// Brief  : Scoreboard bench for mul_div_unit; honours MULDIV_FAST_MUL_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int         MUL_DONE = 2;
  localparam logic [1:0] ABORT_OP = OP_DIV;
`else
  localparam int         MUL_DONE = 34;
  localparam logic [1:0] ABORT_OP = OP_MULT;
`endif
  localparam int DIV_DONE = 34;

  logic         clk = 1'b0;
  logic         reset, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] rs_data, rt_data, wdata, hi, lo;
  logic         busy, done;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic expect_result(input logic [W-1:0] ehi, input logic [W-1:0] elo);
    exp_t e;
    e.hi = ehi;
    e.lo = elo;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every done pulse consumes one expected HI/LO pair.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: actual=1 required=0");
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_hi", hi, mon_e.hi);
        check("sb_lo", lo, mon_e.lo);
      end
    end
  end

  task automatic do_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] ehi,
                       input logic [W-1:0] elo, input int exp_done);
    int busy_n  = 0;
    int done_at = 0;
    expect_result(ehi, elo);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_at = i;
        break;
      end
    end
    check({name, "_latency"}, done_at, exp_done);
    check({name, "_busy_cycles"}, busy_n, exp_done - 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual=expired required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int dones;
    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = OP_MULT; rs_data = '0; rt_data = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    reset = 1'b0;

    do_op("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_DONE);
    do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_DONE);
    do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_DONE);
    do_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_DONE);
    do_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DIV_DONE);
    do_op("div_by_zero", OP_DIV, 32'd25, 32'd0, 32'd25, 32'hFFFF_FFFF, DIV_DONE);

    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", lo, 32'h0000_1234);
    check("mtlo_hi_kept", hi, 32'd25);
    hi_we = 1'b1; wdata = 32'hCAFE_0001;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_hi", hi, 32'hCAFE_0001);

    // A second start and an MTLO during a running DIVU must both be ignored.
    expect_result(32'd2, 32'd14);
    dones = 0;
    start = 1'b1; op = OP_DIVU; rs_data = 32'd100; rt_data = 32'd7;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start = 1'b0; lo_we = 1'b0;
      if (i == 10) begin
        start = 1'b1; op = OP_MULTU; rs_data = 32'd3; rt_data = 32'd3;
        lo_we = 1'b1; wdata = 32'h0000_DEAD;
      end
      if (done) dones++;
    end
    check("busy_ignore_done_pulses", dones, 32'd1);
    check("busy_ignore_lo", lo, 32'd14);
    check("busy_ignore_hi", hi, 32'd2);

    // Reset in the middle of an operation discards it.
    start = 1'b1; op = ABORT_OP; rs_data = 32'd1000; rt_data = 32'd3;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    reset = 1'b0;

    do_op("mult_6x7", OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, MUL_DONE);

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
